// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the programmable datapath sequencer: states, opcodes,
// branch condition codes and small decode helpers.
package datapath_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_CMPI  = 4'hB;
    localparam logic [3:0] OP_BCOND = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;
    localparam logic [3:0] EXT_CMP  = 4'hB;

    localparam logic [3:0] COND_EQ  = 4'h0;
    localparam logic [3:0] COND_NE  = 4'h1;
    localparam logic [3:0] COND_MI  = 4'h2;
    localparam logic [3:0] COND_PL  = 4'h3;
    localparam logic [3:0] COND_AL  = 4'hE;

    function automatic logic is_itype(input logic [3:0] op);
        case (op)
            4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: is_itype = 1'b1;
            default:                                  is_itype = 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/datapath_sequencer_decode.sv
// Combinational instruction decoder: maps one 16-bit instruction plus the latched
// flags onto ALU controls and the instruction class used by the sequencer.
module datapath_sequencer_decode
    import datapath_sequencer_pkg::*;
(
    input  logic [15:0] inst,
    input  logic        z,
    input  logic        n,
    output logic [7:0]  alu_op,
    output logic [7:0]  muxes,
    output logic [15:0] regs_en,
    output logic [15:0] imm,
    output logic        is_alu,
    output logic        is_branch,
    output logic        taken,
    output logic        is_halt
);

    logic [3:0] op_s;
    logic [3:0] rd_s;
    logic [3:0] ext_s;
    logic [3:0] rs_s;

    assign op_s  = inst[15:12];
    assign rd_s  = inst[11:8];
    assign ext_s = inst[7:4];
    assign rs_s  = inst[3:0];

    // Instruction class and datapath control decode
    always_comb begin
        alu_op    = 8'h00;
        muxes     = 8'h00;
        regs_en   = 16'h0000;
        imm       = 16'h0000;
        is_alu    = 1'b0;
        is_branch = 1'b0;
        taken     = 1'b0;
        is_halt   = 1'b0;
        if (op_s == OP_RTYPE) begin
            is_alu = 1'b1;
            alu_op = {4'h0, ext_s};
            muxes  = {rd_s, rs_s};
            if (ext_s == EXT_CMP) begin
                regs_en = 16'h0000;
            end else begin
                regs_en = 16'h0001 << rd_s;
            end
        end else if (is_itype(op_s)) begin
            is_alu = 1'b1;
            alu_op = {op_s, 4'h0};
            muxes  = {rd_s, 4'h0};
            imm    = sext8(inst[7:0]);
            if (op_s == OP_CMPI) begin
                regs_en = 16'h0000;
            end else begin
                regs_en = 16'h0001 << rd_s;
            end
        end else if (op_s == OP_BCOND) begin
            // Condition field reuses the rd slot
            is_branch = 1'b1;
            case (rd_s)
                COND_EQ: taken = z;
                COND_NE: taken = ~z;
                COND_MI: taken = n;
                COND_PL: taken = ~n;
                COND_AL: taken = 1'b1;
                default: taken = 1'b0;
            endcase
        end else if (op_s == OP_HALT) begin
            is_halt = 1'b1;
        end else begin
            is_alu = 1'b0;
        end
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Programmable sequencer for the register-file/ALU datapath: fetches from a
// sync-read instruction memory, two cycles per instruction, start/busy/done handshake.
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] START_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            alu_z,
    input  logic            alu_n,
    output logic [7:0]      alu_op,
    output logic [7:0]      muxes,
    output logic [15:0]     regs_en,
    output logic [15:0]     imm,
    output logic            busy,
    output logic            done
);

    state_e          state_r;
    state_e          state_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_s;
    logic            z_r;
    logic            z_s;
    logic            n_r;
    logic            n_s;

    logic [7:0]      dec_alu_op_s;
    logic [7:0]      dec_muxes_s;
    logic [15:0]     dec_regs_en_s;
    logic [15:0]     dec_imm_s;
    logic            is_alu_s;
    logic            is_branch_s;
    logic            taken_s;
    logic            is_halt_s;
    logic [15:0]     disp_s;
    logic            exec_s;

    datapath_sequencer_decode u_decode (
        .inst      (imem_rdata),
        .z         (z_r),
        .n         (n_r),
        .alu_op    (dec_alu_op_s),
        .muxes     (dec_muxes_s),
        .regs_en   (dec_regs_en_s),
        .imm       (dec_imm_s),
        .is_alu    (is_alu_s),
        .is_branch (is_branch_s),
        .taken     (taken_s),
        .is_halt   (is_halt_s)
    );

    assign disp_s    = sext8(imem_rdata[7:0]);
    assign exec_s    = (state_r == ST_EXEC);
    assign imem_addr = pc_r;
    assign busy      = (state_r == ST_FETCH) || (state_r == ST_EXEC);
    assign done      = (state_r == ST_DONE);

    // State, program counter and flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            pc_r    <= START_PC;
            z_r     <= 1'b0;
            n_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            z_r     <= z_s;
            n_r     <= n_s;
        end
    end

    // Next-state, pc sequencing and flag capture
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        z_s     = z_r;
        n_s     = n_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_FETCH;
                    pc_s    = START_PC;
                    z_s     = 1'b0;
                    n_s     = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_alu_s) begin
                    z_s = alu_z;
                    n_s = alu_n;
                end else begin
                    z_s = z_r;
                    n_s = n_r;
                end
                // Branch arithmetic is done at 16 bits and truncated, giving modulo wrap
                if (is_halt_s) begin
                    state_s = ST_DONE;
                    pc_s    = pc_r;
                end else if (is_branch_s && taken_s) begin
                    state_s = ST_FETCH;
                    pc_s    = PC_W'(16'(pc_r) + disp_s);
                end else begin
                    state_s = ST_FETCH;
                    pc_s    = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Decoded controls reach the datapath only while an instruction executes
    always_comb begin
        if (exec_s) begin
            alu_op  = dec_alu_op_s;
            muxes   = dec_muxes_s;
            regs_en = dec_regs_en_s;
            imm     = dec_imm_s;
        end else begin
            alu_op  = 8'h00;
            muxes   = 8'h00;
            regs_en = 16'h0000;
            imm     = 16'h0000;
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed programs plus random
// programs, checked against an instruction-level reference model.
module tb_datapath_sequencer;

    localparam int PC_W = 8;
    localparam int MEM_N = 256;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic            alu_z;
    logic            alu_n;
    logic [7:0]      alu_op;
    logic [7:0]      muxes;
    logic [15:0]     regs_en;
    logic [15:0]     imm;
    logic            busy;
    logic            done;

    logic [15:0] mem [0:MEM_N-1];
    logic [15:0] rf  [0:15];
    int          op_cnt [0:15];
    int          n_checks = 0;
    int          n_pass = 0;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  mx;
        logic [15:0] en;
        logic [15:0] im;
    } exp_t;

    datapath_sequencer #(.PC_W(PC_W), .START_PC(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .alu_op     (alu_op),
        .muxes      (muxes),
        .regs_en    (regs_en),
        .imm        (imm),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".alu_op"},  32'(alu_op),  32'h0);
        chk({tag, ".muxes"},   32'(muxes),   32'h0);
        chk({tag, ".regs_en"}, 32'(regs_en), 32'h0);
        chk({tag, ".imm"},     32'(imm),     32'h0);
    endtask

    function automatic exp_t ref_decode(input logic [15:0] w);
        exp_t e;
        int op, rd, ext, rs;
        op = int'(w[15:12]); rd = int'(w[11:8]); ext = int'(w[7:4]); rs = int'(w[3:0]);
        e = '0;
        if (op == 0) begin
            e.op = 8'(ext);
            e.mx = 8'(rd * 16 + rs);
            e.en = (ext == 11) ? 16'h0 : 16'(1 << rd);
        end else if (op inside {1, 2, 3, 5, 9, 11, 13}) begin
            e.op = 8'(op * 16);
            e.mx = 8'(rd * 16);
            e.im = 16'($signed(w[7:0]));
            e.en = (op == 11) ? 16'h0 : 16'(1 << rd);
        end
        return e;
    endfunction

    function automatic bit ref_taken(input int cond, input bit z, input bit n);
        case (cond)
            0:       return z;
            1:       return !z;
            2:       return n;
            3:       return !n;
            14:      return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < MEM_N; i++) mem[i] = 16'hF000;
        for (int i = 0; i < 16; i++) op_cnt[i] = 0;
    endtask

    // Runs one program from IDLE; ends at an IDLE negedge if it halted,
    // otherwise at the negedge of the last modelled EXEC cycle.
    task automatic run(input int max_instr, input bit hold, input bit noise,
                       output bit halted, output int n_exec);
        int m_pc, op, rd, ext, rs;
        bit m_z, m_n, known;
        logic [15:0] w, res, immv;
        exp_t e;
        halted = 1'b0; n_exec = 0;
        m_pc = 0; m_z = 1'b0; m_n = 1'b0;
        chk("idle.busy", 32'(busy), 32'd0);
        chk("idle.done", 32'(done), 32'd0);
        start = 1'b1;
        while (!halted && n_exec < max_instr) begin
            @(negedge clk);
            start = hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            {alu_z, alu_n} = 2'($urandom_range(0, 3));
            chk("fetch.busy", 32'(busy), 32'd1);
            chk("fetch.done", 32'(done), 32'd0);
            chk("fetch.addr", 32'(imem_addr), 32'(m_pc));
            chk_quiet("fetch");
            @(negedge clk);
            start = hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            w = mem[m_pc];
            op = int'(w[15:12]); rd = int'(w[11:8]); ext = int'(w[7:4]); rs = int'(w[3:0]);
            immv = 16'($signed(w[7:0]));
            known = 1'b1;
            if (op == 0 && ext == 5)  res = rf[rd] + rf[rs];
            else if (op == 5)         res = rf[rd] + immv;
            else if (op == 9)         res = rf[rd] - immv;
            else if (op == 13)        res = immv;
            else begin known = 1'b0; res = 16'h0; end
            if (known) {alu_z, alu_n} = {res == 16'h0, res[15]};
            else       {alu_z, alu_n} = 2'($urandom_range(0, 3));
            e = ref_decode(w);
            chk("exec.busy",    32'(busy),    32'd1);
            chk("exec.addr",    32'(imem_addr), 32'(m_pc));
            chk("exec.alu_op",  32'(alu_op),  32'(e.op));
            chk("exec.muxes",   32'(muxes),   32'(e.mx));
            chk("exec.regs_en", 32'(regs_en), 32'(e.en));
            chk("exec.imm",     32'(imm),     32'(e.im));
            n_exec++;
            op_cnt[op]++;
            if (op == 15)                                 halted = 1'b1;
            else if (op == 12 && ref_taken(rd, m_z, m_n)) m_pc = (m_pc + int'($signed(w[7:0]))) & (MEM_N - 1);
            else                                          m_pc = (m_pc + 1) & (MEM_N - 1);
            if (op == 0 || op inside {1, 2, 3, 5, 9, 11, 13}) begin
                m_z = alu_z; m_n = alu_n;
            end
            if (known && e.en != 16'h0) rf[rd] = res;
        end
        if (halted) begin
            @(negedge clk);
            start = hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            chk("done.done", 32'(done), 32'd1);
            chk("done.busy", 32'(busy), 32'd0);
            chk("done.addr", 32'(imem_addr), 32'(m_pc));
            chk_quiet("done");
            @(negedge clk);
            start = hold;
            chk("post.done", 32'(done), 32'd0);
            chk("post.busy", 32'(busy), 32'd0);
        end
    endtask

    // Called at an EXEC negedge of an unfinished program
    task automatic reset_mid_exec(input string tag);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, ".pre_busy"}, 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk_quiet(tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".addr"}, 32'(imem_addr), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
            chk({tag, ".idle_en"},   32'(regs_en), 32'd0);
            chk({tag, ".idle_addr"}, 32'(imem_addr), 32'd0);
        end
    endtask

    initial begin
        bit h;
        int n;
        reset = 1'b0; start = 1'b0; alu_z = 1'b0; alu_n = 1'b0;
        for (int i = 0; i < 16; i++) rf[i] = 16'h0;
        clear_prog();
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.addr", 32'(imem_addr), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Fibonacci-style ADD chain
        clear_prog();
        mem[0] = 16'h5101; mem[1] = 16'h0250; mem[2] = 16'h0351;
        mem[3] = 16'h0452; mem[4] = 16'h0553; mem[5] = 16'hF000;
        run(20, 1'b0, 1'b0, h, n);
        chk("fib.halted", 32'(h), 32'd1);
        chk("fib.count",  32'(n), 32'd6);

        // Countdown loop: SUBI three times, BNE falls through on z
        clear_prog();
        mem[0] = 16'hD103; mem[1] = 16'h9101; mem[2] = 16'hC1FF; mem[3] = 16'hF000;
        run(20, 1'b0, 1'b0, h, n);
        chk("cd.halted", 32'(h), 32'd1);
        chk("cd.count",  32'(n), 32'd8);
        chk("cd.subi",   32'(op_cnt[9]), 32'd3);

        // Branch never then branch always +2
        clear_prog();
        mem[0] = 16'hC5AA; mem[1] = 16'hCE02; mem[2] = 16'h5101; mem[3] = 16'hF000;
        run(20, 1'b0, 1'b0, h, n);
        chk("br.count",   32'(n), 32'd3);
        chk("br.skipped", 32'(op_cnt[5]), 32'd0);

        // start noise while busy, then start held through DONE for an immediate restart
        clear_prog();
        mem[0] = 16'hD103; mem[1] = 16'h9101; mem[2] = 16'hC1FF; mem[3] = 16'hF000;
        run(20, 1'b0, 1'b1, h, n);
        chk("noise.count", 32'(n), 32'd8);
        run(20, 1'b1, 1'b0, h, n);
        chk("hold1.count", 32'(n), 32'd8);
        run(20, 1'b0, 1'b1, h, n);
        chk("hold2.count", 32'(n), 32'd8);

        // Backward branch wraps below 0, sequential flow wraps past 255
        clear_prog();
        mem[0] = 16'hC1FE; mem[254] = 16'hD200; mem[255] = 16'h4000; mem[1] = 16'hF000;
        run(20, 1'b0, 1'b0, h, n);
        chk("wrap.halted", 32'(h), 32'd1);
        chk("wrap.count",  32'(n), 32'd5);

        // Spin on taken branch with zero displacement; only reset exits
        clear_prog();
        mem[0] = 16'hCE00;
        run(8, 1'b0, 1'b1, h, n);
        chk("spin.halted", 32'(h), 32'd0);
        reset_mid_exec("spin_rst");

        // Random programs, aborted by reset if they do not halt
        for (int r = 0; r < 4; r++) begin
            clear_prog();
            for (int i = 0; i < MEM_N; i++) mem[i] = 16'($urandom);
            run(40, 1'b0, 1'b1, h, n);
            if (!h) reset_mid_exec("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
